// File: rtl/led_pattern_sequencer_pkg.sv
// Shared mode/direction encodings for the LED pattern sequencer.
package led_seq_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_BLINK  = 2'd0;
    localparam logic [MODE_W-1:0] MODE_CHASE  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BOUNCE = 2'd2;
    localparam logic [MODE_W-1:0] MODE_COUNT  = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [MODE_W-1:0] {
        ST_BLINK  = MODE_BLINK,
        ST_CHASE  = MODE_CHASE,
        ST_BOUNCE = MODE_BOUNCE,
        ST_COUNT  = MODE_COUNT
    } mode_e;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            ST_BLINK:  next_mode = ST_CHASE;
            ST_CHASE:  next_mode = ST_BOUNCE;
            ST_BOUNCE: next_mode = ST_COUNT;
            default:   next_mode = ST_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_btn_debounce.sv
// Push-button conditioning: 2-FF synchronizer, stability counter and
// a single-cycle press pulse on an accepted 0->1 transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clkin,
    input  logic rstn,
    input  logic btn_in,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_btn_s;
    logic             w_done;

    assign w_btn_s = r_sync2;
    assign w_done  = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clkin) begin
        if (!rstn) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            // Any sample agreeing with the accepted level restarts the window.
            if (w_btn_s == r_stable) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_stable <= w_btn_s;
                r_cnt    <= '0;
                r_press  <= w_btn_s;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps a multi-LED pattern on each rising edge of the blink wave; a debounced
// button cycles BLINK -> CHASE -> BOUNCE -> COUNT.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LEDS          = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clkin,
    input  logic              rstn,
    input  logic              blink_in,
    input  logic              btn_in,
    output logic [N_LEDS-1:0] outleds,
    output logic [MODE_W-1:0] mode_out
);

    logic              r_blink_q;
    mode_e             r_mode;
    logic              r_dir;
    logic [N_LEDS-1:0] r_leds;

    logic              w_step;
    logic              w_press;
    mode_e             w_mode_nxt;
    logic              w_dir_nxt;
    logic [N_LEDS-1:0] w_leds_nxt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clkin (clkin),
        .rstn  (rstn),
        .btn_in(btn_in),
        .press (w_press)
    );

    assign w_step = blink_in & ~r_blink_q;

    always_comb begin
        w_mode_nxt = r_mode;
        w_dir_nxt  = r_dir;
        w_leds_nxt = r_leds;
        // A press outranks a coincident step; that step is simply dropped.
        if (w_press) begin
            w_mode_nxt = next_mode(r_mode);
            w_dir_nxt  = DIR_LEFT;
            if (w_mode_nxt == ST_CHASE || w_mode_nxt == ST_BOUNCE)
                w_leds_nxt = N_LEDS'(1);
            else
                w_leds_nxt = '0;
        end else if (w_step) begin
            case (r_mode)
                ST_BLINK: w_leds_nxt = ~r_leds;
                ST_CHASE: w_leds_nxt = {r_leds[N_LEDS-2:0], r_leds[N_LEDS-1]};
                ST_BOUNCE: begin
                    // Reversal and the shift happen on the same step: no dwell at the ends.
                    if (r_dir == DIR_LEFT) begin
                        if (r_leds[N_LEDS-1]) begin
                            w_dir_nxt  = DIR_RIGHT;
                            w_leds_nxt = r_leds >> 1;
                        end else begin
                            w_leds_nxt = r_leds << 1;
                        end
                    end else begin
                        if (r_leds[0]) begin
                            w_dir_nxt  = DIR_LEFT;
                            w_leds_nxt = r_leds << 1;
                        end else begin
                            w_leds_nxt = r_leds >> 1;
                        end
                    end
                end
                default: w_leds_nxt = r_leds + N_LEDS'(1);
            endcase
        end
    end

    always_ff @(posedge clkin) begin
        if (!rstn) begin
            r_blink_q <= 1'b0;
            r_mode    <= ST_BLINK;
            r_dir     <= DIR_LEFT;
            r_leds    <= '0;
        end else begin
            r_blink_q <= blink_in;
            r_mode    <= w_mode_nxt;
            r_dir     <= w_dir_nxt;
            r_leds    <= w_leds_nxt;
        end
    end

    assign outleds  = r_leds;
    assign mode_out = r_mode;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with N_LEDS=4, DEBOUNCE_CYCLES=4.
module tb_led_pattern_sequencer;

    logic       clkin = 1'b0;
    logic       rstn;
    logic       blink_in;
    logic       btn_in;
    logic [3:0] outleds;
    logic [1:0] mode_out;

    int total = 0;
    int bad   = 0;

    led_pattern_sequencer #(
        .N_LEDS         (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clkin   (clkin),
        .rstn    (rstn),
        .blink_in(blink_in),
        .btn_in  (btn_in),
        .outleds (outleds),
        .mode_out(mode_out)
    );

    always #5 clkin = ~clkin;

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] el, input logic [1:0] em);
        total++;
        assert (outleds === el) else begin
            bad++;
            $error("FAIL %s outleds got=%b exp=%b", tag, outleds, el);
        end
        total++;
        assert (mode_out === em) else begin
            bad++;
            $error("FAIL %s mode_out got=%0d exp=%0d", tag, mode_out, em);
        end
    endtask

    task automatic step();
        blink_in = 1'b1;
        tick();
        blink_in = 1'b0;
        tick();
    endtask

    // Clean press held long enough to debounce, then released and settled.
    task automatic press();
        btn_in = 1'b1;
        repeat (10) tick();
        btn_in = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        logic [3:0] exp_l;
        logic [3:0] chase_seq [5];
        logic [3:0] bounce_seq [7];
        chase_seq  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        bounce_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

        // 1. reset with activity on the inputs
        rstn     = 1'b0;
        btn_in   = 1'b1;
        blink_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            blink_in = ~blink_in;
            tick();
            chk("reset_hold", 4'b0000, 2'd0);
        end
        blink_in = 1'b0;
        btn_in   = 1'b0;
        rstn     = 1'b1;
        repeat (3) tick();
        chk("reset_release", 4'b0000, 2'd0);

        // 2. BLINK
        step(); chk("blink_1", 4'b1111, 2'd0);
        step(); chk("blink_2", 4'b0000, 2'd0);
        blink_in = 1'b1;
        tick(); chk("blink_3_latency", 4'b1111, 2'd0);
        blink_in = 1'b0;
        tick(); chk("blink_3_fall", 4'b1111, 2'd0);
        blink_in = 1'b1;
        tick(); chk("blink_held_edge", 4'b0000, 2'd0);
        repeat (9) tick();
        chk("blink_held_10", 4'b0000, 2'd0);
        blink_in = 1'b0;
        tick(); chk("blink_held_fall", 4'b0000, 2'd0);

        // 3. CHASE
        press(); chk("chase_reload", 4'b0001, 2'd1);
        for (int i = 0; i < 5; i++) begin
            step(); chk($sformatf("chase_%0d", i), chase_seq[i], 2'd1);
        end

        // 4. BOUNCE
        press(); chk("bounce_reload", 4'b0001, 2'd2);
        for (int i = 0; i < 7; i++) begin
            step(); chk($sformatf("bounce_%0d", i), bounce_seq[i], 2'd2);
        end

        // 5. COUNT and wrap back to BLINK
        press(); chk("count_reload", 4'b0000, 2'd3);
        for (int i = 1; i <= 16; i++) begin
            exp_l = 4'(i);
            step(); chk($sformatf("count_%0d", i), exp_l, 2'd3);
        end
        press(); chk("blink_again", 4'b0000, 2'd0);

        // 6a. short bounces must never be accepted
        for (int i = 0; i < 4; i++) begin
            btn_in = 1'b1;
            repeat (3) tick();
            btn_in = 1'b0;
            repeat (3) tick();
        end
        repeat (10) tick();
        chk("glitch_rejected", 4'b0000, 2'd0);

        // 6b. press pulse lands on the same edge as a step
        btn_in = 1'b1;
        repeat (6) tick();
        blink_in = 1'b1;
        tick(); chk("press_vs_step", 4'b0001, 2'd1);
        tick(); chk("press_vs_step_after", 4'b0001, 2'd1);
        btn_in   = 1'b0;
        blink_in = 1'b0;
        repeat (8) tick();
        chk("press_vs_step_settle", 4'b0001, 2'd1);

        // 6c. reset in the middle of COUNT
        press(); press();
        chk("count_again", 4'b0000, 2'd3);
        step(); step(); step();
        chk("count_mid", 4'b0011, 2'd3);
        rstn = 1'b0;
        tick(); chk("count_reset", 4'b0000, 2'd0);
        rstn = 1'b1;
        repeat (3) tick();
        chk("count_reset_release", 4'b0000, 2'd0);
        step(); chk("post_reset_blink", 4'b1111, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
